cache_ctrl_burst: RTL
=====================

// Module: cache_ctrl_burst
// PURPOSE
//  Next-generation cache controller FSM: sits between CPU port and cache datapath, drives physical memory.
//  Adds multi-beat line transfers (BURST_LEN beats per line, beat_idx to datapath), optional no-write-allocate
//  write-around, and saturating hit/miss/writeback counters. Datapath signal contract matches the current controller.
// PARAMETERS
//  BURST_LEN   4   beats per cache line on pmem; >=1; BURST_LEN=1 reproduces single-transfer behaviour
//  WRITE_ALLOC 1   1: write miss allocates line; 0: write miss goes straight to pmem (write-around), no fill
//  CNT_W       32  width of each performance counter
//  (local) BEAT_W = max($clog2(BURST_LEN),1)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous active-low reset (asserted at 0)
//  mem_read    in   1       CPU read request, held until mem_resp
//  mem_write   in   1       CPU write request, held until mem_resp
//  mem_resp    out  1       CPU request complete (1-cycle pulse)
//  pmem_resp   in   1       pmem accepted/returned one beat this cycle
//  pmem_read   out  1       pmem read (line fill) request
//  pmem_write  out  1       pmem write (writeback or write-around) request
//  hit_sig     in   1       datapath: tag hit
//  dirty_sig   in   1       datapath: victim way is dirty
//  allo_sig    out  1       datapath: select fill address/data path
//  rep_sig     out  1       datapath: select victim way
//  bypass_sig  out  1       datapath: route CPU word/address to pmem (write-around)
//  beat_idx    out  BEAT_W  current beat within line
//  load_data   out  1       write-enable data array (per beat during fill)
//  load_tag, load_valid, load_dirty, load_plru  out 1 each  array write-enables
//  valid_i, dirty_i  out 1 each  values written to valid/dirty arrays
//  clr_cnt     in   1       synchronous clear of all counters
//  hit_cnt, miss_cnt, wb_cnt  out CNT_W each  performance counters
// BEHAVIOUR
//  States: IDLE, TAG_COMPARE, WRITE_BACK, ALLOCATE, WRITE_AROUND. Outputs combinational from state+inputs; all 0 unless listed.
//  Reset (rst=0, async): state=IDLE, beat counter=0, retry flag=0, counters=0; all outputs 0 immediately, incl. mid-burst.
//  IDLE: mem_read|mem_write -> TAG_COMPARE. Both asserted is treated as write.
//  TAG_COMPARE hit: mem_resp=1, load_plru=1; if write also load_data=load_dirty=dirty_i=1; -> IDLE. Hit latency 2 cycles.
//  TAG_COMPARE miss: write & WRITE_ALLOC=0 -> WRITE_AROUND; else dirty_sig -> WRITE_BACK; else -> ALLOCATE.
//  WRITE_BACK: rep_sig=pmem_write=1; beat counter +1 per pmem_resp; pmem_resp on beat BURST_LEN-1 -> ALLOCATE, counter=0.
//  ALLOCATE: pmem_read=allo_sig=rep_sig=1; load_data=pmem_resp (per-beat enable); on last-beat pmem_resp also
//   load_tag=load_valid=load_dirty=1, valid_i=1, dirty_i=0, counter=0, retry flag=1 -> TAG_COMPARE.
//  WRITE_AROUND: pmem_write=bypass_sig=1, single beat; on pmem_resp mem_resp=1 same cycle -> IDLE; no array updates.
//  beat_idx = counter; wraps BURST_LEN-1 -> 0 only via state exit; never exceeds BURST_LEN-1.
//  pmem_read/pmem_write held high through all beats of a burst; never both high.
//  Counters (saturate at all-ones, no wrap): miss_cnt +1 on TAG_COMPARE miss; hit_cnt +1 on TAG_COMPARE hit with
//   retry flag=0 (post-fill re-compare not counted); wb_cnt +1 on WRITE_BACK entry. Retry flag clears on mem_resp.
//  clr_cnt has priority over same-cycle increment. CPU request deassert mid-miss is illegal; controller completes burst.
// STRUCTURE
//  cache_ctrl_pkg: state enum cache_ctrl_state_t, function beat_w(BURST_LEN).
//  Sub-module cache_perf_cnt (CNT_W saturating counter, inc/clr inputs) instantiated x3; FSM+beat counter inline.
// TESTING
//  Read hit: mem_read=1, hit_sig=1 -> mem_resp at cycle 2, load_plru=1, hit_cnt=1, no pmem activity.
//  Clean read miss, BURST_LEN=4: pmem_resp each 3rd cycle -> 4 load_data pulses, beat_idx 0..3, load_tag on beat 3,
//   re-compare hit -> mem_resp; miss_cnt=1, hit_cnt=0.
//  Dirty write miss: dirty_sig=1 -> 4 writeback beats, wb_cnt=1, then 4-beat fill, final write hit dirty_i=1.
//  WRITE_ALLOC=0 write miss -> WRITE_AROUND, pmem_write+bypass_sig until pmem_resp, mem_resp same cycle, no load_*.
//  rst=0 at beat 2 of fill -> pmem_read, beat_idx, counters all 0 without clock edge; next request starts clean.
//  Counter saturation with CNT_W=4: 16 hits -> hit_cnt stays 4'hF; clr_cnt with concurrent hit -> 0.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the burst-capable cache controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_TAG_COMPARE  = 3'd1,
    ST_WRITE_BACK   = 3'd2,
    ST_ALLOCATE     = 3'd3,
    ST_WRITE_AROUND = 3'd4
  } cache_ctrl_state_t;

  // A beat index needs at least one bit, even for single-beat lines.
  function automatic int beat_w(input int burst_len);
    return (burst_len <= 1) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Saturating performance counter with synchronous clear (clear wins over increment).
module cache_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl_burst.sv
// Cache controller FSM with multi-beat line fill/writeback, optional write-around
// on write miss, and saturating hit/miss/writeback counters.
//
// state           | meaning
// ST_IDLE         | waiting for a CPU read or write request
// ST_TAG_COMPARE  | datapath tag lookup; hit completes, miss picks a path
// ST_WRITE_BACK   | streaming the dirty victim line to pmem, one beat per pmem_resp
// ST_ALLOCATE     | filling the line from pmem, then re-compare
// ST_WRITE_AROUND | write miss without allocation: single word straight to pmem
module cache_ctrl_burst
  import cache_ctrl_pkg::*;
#(
  parameter int BURST_LEN   = 4,
  parameter bit WRITE_ALLOC = 1'b1,
  parameter int CNT_W       = 32,
  localparam int BEAT_W     = beat_w(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_resp,
  input  logic              pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              hit_sig,
  input  logic              dirty_sig,
  output logic              allo_sig,
  output logic              rep_sig,
  output logic              bypass_sig,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              load_data,
  output logic              load_tag,
  output logic              load_valid,
  output logic              load_dirty,
  output logic              load_plru,
  output logic              valid_i,
  output logic              dirty_i,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  cache_ctrl_state_t state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              retry_q, retry_d;
  logic              hit_inc, miss_inc, wb_inc;
  logic              last_beat;

  assign beat_idx  = beat_q;
  assign last_beat = (beat_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    retry_d    = retry_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    allo_sig   = 1'b0;
    rep_sig    = 1'b0;
    bypass_sig = 1'b0;
    load_data  = 1'b0;
    load_tag   = 1'b0;
    load_valid = 1'b0;
    load_dirty = 1'b0;
    load_plru  = 1'b0;
    valid_i    = 1'b0;
    dirty_i    = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    wb_inc     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) state_d = ST_TAG_COMPARE;
      end

      ST_TAG_COMPARE: begin
        if (hit_sig) begin
          mem_resp  = 1'b1;
          load_plru = 1'b1;
          // mem_write wins when both requests are up
          if (mem_write) begin
            load_data  = 1'b1;
            load_dirty = 1'b1;
            dirty_i    = 1'b1;
          end
          hit_inc = !retry_q;
          state_d = ST_IDLE;
        end else begin
          miss_inc = 1'b1;
          if (mem_write && !WRITE_ALLOC) begin
            state_d = ST_WRITE_AROUND;
          end else if (dirty_sig) begin
            wb_inc  = 1'b1;
            state_d = ST_WRITE_BACK;
          end else begin
            state_d = ST_ALLOCATE;
          end
        end
      end

      ST_WRITE_BACK: begin
        rep_sig    = 1'b1;
        pmem_write = 1'b1;
        if (pmem_resp) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = ST_ALLOCATE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      ST_ALLOCATE: begin
        pmem_read = 1'b1;
        allo_sig  = 1'b1;
        rep_sig   = 1'b1;
        load_data = pmem_resp;
        if (pmem_resp) begin
          if (last_beat) begin
            load_tag   = 1'b1;
            load_valid = 1'b1;
            load_dirty = 1'b1;
            valid_i    = 1'b1;
            beat_d     = '0;
            retry_d    = 1'b1;
            state_d    = ST_TAG_COMPARE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      ST_WRITE_AROUND: begin
        pmem_write = 1'b1;
        bypass_sig = 1'b1;
        if (pmem_resp) begin
          mem_resp = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase

    // The post-fill re-compare is excluded from hit_cnt until the request completes.
    if (mem_resp) retry_d = 1'b0;
  end

  cache_perf_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (hit_inc),
    .cnt (hit_cnt)
  );

  cache_perf_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (miss_inc),
    .cnt (miss_cnt)
  );

  cache_perf_cnt #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (wb_inc),
    .cnt (wb_cnt)
  );

endmodule
